// File: rtl/fwc_pkg.sv
// Shared definitions for the flash write controller: state encoding,
// default bus timing and the phase-timer width.
package fwc_pkg;

  localparam int DEF_SETUP_CYC = 2;
  localparam int DEF_PULSE_CYC = 5;
  localparam int DEF_HOLD_CYC  = 2;

  localparam int CNT_W = 4;

  typedef logic [2:0] fwc_state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_PULSE = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // The three states in which the flash bus is actively driven.
  function automatic logic is_timed(input logic [2:0] s);
    return (s == ST_SETUP) || (s == ST_PULSE) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Generic up-counter with synchronous clear and count enable; clear wins.
import fwc_pkg::*;

module flex_counter #(
  parameter int NUM_CNT_BITS = CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    count_enable,
  output logic [NUM_CNT_BITS-1:0] count_out
);

  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_out <= '0;
    end else if (clear) begin
      count_out <= '0;
    end else if (count_enable) begin
      count_out <= count_out + CNT_ONE;
    end
  end

endmodule

// File: rtl/flash_write_ctrl.sv
// Flash write sequencer: SETUP / WE-PULSE / HOLD timing on a parallel NOR-style
// bus, with a one-entry pending slot so back-to-back writes have no idle gap.
module flash_write_ctrl import fwc_pkg::*; #(
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_req,
  input  logic [15:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        wr_ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] flash_addr,
  output logic [15:0] flash_dq,
  output logic        dq_oe,
  output logic        ce,
  output logic        oe,
  output logic        we
);

  // Each phase length must fit the 4-bit timer (1..15).
  localparam logic [CNT_W-1:0] SETUP_LEN = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] PULSE_LEN = CNT_W'(PULSE_CYC);
  localparam logic [CNT_W-1:0] HOLD_LEN  = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  fwc_state_t       state_reg, state_next;
  logic             pending_valid_reg;
  logic [15:0]      pending_addr_reg, pending_data_reg;
  logic [15:0]      active_addr_reg, active_data_reg;
  logic             accept, load_request, load_pending, store_pending;
  logic             phase_en, phase_clear, phase_done;
  logic [CNT_W-1:0] phase_count, phase_len;

  assign wr_ready = ~pending_valid_reg;
  assign accept   = wr_req & wr_ready;

  always_comb begin
    phase_len = SETUP_LEN;
    case (state_reg)
      ST_PULSE: phase_len = PULSE_LEN;
      ST_HOLD:  phase_len = HOLD_LEN;
      default:  phase_len = SETUP_LEN;
    endcase
  end

  // The count holds cycles already spent in the phase; the phase ends on the
  // edge where the incremented count reaches the phase length.
  assign phase_en    = is_timed(state_reg);
  assign phase_clear = (state_next != state_reg);
  assign phase_done  = phase_en && ((phase_count + CNT_ONE) == phase_len);

  flex_counter #(.NUM_CNT_BITS(CNT_W)) u_phase_timer (
    .clk          (clk),
    .rst          (rst),
    .clear        (phase_clear),
    .count_enable (phase_en),
    .count_out    (phase_count)
  );

  always_comb begin
    state_next   = state_reg;
    load_request = 1'b0;
    load_pending = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          load_request = 1'b1;
          state_next   = ST_SETUP;
        end
      end
      ST_SETUP: if (phase_done) state_next = ST_PULSE;
      ST_PULSE: if (phase_done) state_next = ST_HOLD;
      ST_HOLD:  if (phase_done) state_next = ST_DONE;
      ST_DONE: begin
        // A queued write outranks one offered in this very cycle.
        if (pending_valid_reg) begin
          load_pending = 1'b1;
          state_next   = ST_SETUP;
        end else if (accept) begin
          load_request = 1'b1;
          state_next   = ST_SETUP;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign store_pending = accept && is_timed(state_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= ST_IDLE;
      pending_valid_reg <= 1'b0;
      pending_addr_reg  <= '0;
      pending_data_reg  <= '0;
      active_addr_reg   <= '0;
      active_data_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (load_pending) begin
        active_addr_reg <= pending_addr_reg;
        active_data_reg <= pending_data_reg;
      end else if (load_request) begin
        active_addr_reg <= wr_addr;
        active_data_reg <= wr_data;
      end
      if (store_pending) begin
        pending_valid_reg <= 1'b1;
        pending_addr_reg  <= wr_addr;
        pending_data_reg  <= wr_data;
      end else if (load_pending) begin
        pending_valid_reg <= 1'b0;
      end
    end
  end

  // Strobes decode straight from the state register so reset releases them at once.
  assign ce         = ~is_timed(state_reg);
  assign we         = (state_reg != ST_PULSE);
  assign oe         = 1'b1;
  assign dq_oe      = is_timed(state_reg);
  assign done       = (state_reg == ST_DONE);
  assign busy       = (state_reg != ST_IDLE) || pending_valid_reg;
  assign flash_addr = active_addr_reg;
  assign flash_dq   = active_data_reg;

endmodule

// File: tb/tb_flash_write_ctrl.sv
// Scoreboard bench for flash_write_ctrl: default-timing instance for the main
// scenarios plus a 1/1/1 instance for the shortest legal timing.
module tb_flash_write_ctrl;

  localparam int LAT = 2 + 5 + 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wr_req, wr_ready, busy, done, dq_oe, ce, oe, we;
  logic [15:0] wr_addr, wr_data, flash_addr, flash_dq;

  logic        rst_f, wr_req_f, wr_ready_f, busy_f, done_f, dq_oe_f, ce_f, oe_f, we_f;
  logic [15:0] wr_addr_f, wr_data_f, flash_addr_f, flash_dq_f;

  flash_write_ctrl dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .busy(busy), .done(done), .flash_addr(flash_addr),
    .flash_dq(flash_dq), .dq_oe(dq_oe), .ce(ce), .oe(oe), .we(we)
  );

  flash_write_ctrl #(.SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)) dut_fast (
    .clk(clk), .rst(rst_f), .wr_req(wr_req_f), .wr_addr(wr_addr_f), .wr_data(wr_data_f),
    .wr_ready(wr_ready_f), .busy(busy_f), .done(done_f), .flash_addr(flash_addr_f),
    .flash_dq(flash_dq_f), .dq_oe(dq_oe_f), .ce(ce_f), .oe(oe_f), .we(we_f)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t sb_q[$];
  int   last_due = 0;
  int   done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; holds the request until accepted, then records the
  // expected completion edge: a write starts on its accept edge or on the edge
  // after the previous write's DONE, whichever is later.
  task automatic send(input logic [15:0] a, input logic [15:0] d);
    bit ok = 0;
    int start;
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    for (int n = 0; n < 60; n++) begin
      if (wr_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("accept_wait", 32'(ok), 1);
    if (ok) begin
      start    = (cyc + 1 > last_due + 1) ? cyc + 1 : last_due + 1;
      last_due = start + LAT;
      sb_q.push_back('{a, d, last_due});
    end
    @(posedge clk);
    #1 wr_req = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int n = 0; n < budget && sb_q.size() != 0; n++) @(negedge clk);
    chk("drain", sb_q.size(), 0);
  endtask

  // Monitor: per-write strobe timing and bus stability, scoreboard pop on done.
  int ce_run = 0, we_run = 0, we_off = -1, unstable = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        ce_run = 0; we_run = 0; we_off = -1; unstable = 0;
      end else begin
        if (!ce) begin
          if (!we) begin
            if (we_run == 0) we_off = ce_run;
            we_run++;
          end
          ce_run++;
          if (sb_q.size() > 0 &&
              (flash_addr !== sb_q[0].addr || flash_dq !== sb_q[0].data || dq_oe !== 1'b1))
            unstable++;
        end
        if (done) begin
          done_cnt++;
          if (sb_q.size() == 0) begin
            chk("spurious_done", sb_q.size(), 1);
          end else begin
            e = sb_q.pop_front();
            $display("txn addr=%h data=%h done_cyc=%0d exp_cyc=%0d", flash_addr, flash_dq, cyc, e.due);
            chk("done_cycle", cyc, e.due);
            chk("done_addr", flash_addr, e.addr);
            chk("done_data", flash_dq, e.data);
            chk("ce_low_cycles", ce_run, 9);
            chk("we_low_cycles", we_run, 5);
            chk("we_fall_offset", we_off, 2);
            chk("bus_stable", unstable, 0);
            chk("done_ce_we_dqoe", {ce, we, oe, dq_oe}, 4'b1110);
          end
          ce_run = 0; we_run = 0; we_off = -1; unstable = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int done_at;
    int we_lo;
    rst = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
    rst_f = 1'b1; wr_req_f = 1'b0; wr_addr_f = '0; wr_data_f = '0;
    #12;
    chk("rst_strobes", {ce, we, oe, dq_oe, done}, 5'b11100);
    chk("rst_busy_ready", {busy, wr_ready}, 2'b01);
    chk("rst_addr", flash_addr, 16'h0000);
    chk("rst_dq", flash_dq, 16'h0000);
    @(negedge clk);
    rst = 1'b0; rst_f = 1'b0;
    @(negedge clk);

    // Single write from idle
    send(16'h1234, 16'hBEEF);
    drain(30);
    @(negedge clk);
    chk("single_busy_after", busy, 0);

    // A, B accepted in A's pulse, C held off while B pending
    base = done_cnt;
    send(16'h0001, 16'h1111);
    for (int n = 0; n < 20 && we; n++) @(negedge clk);
    chk("a_in_pulse", we, 0);
    send(16'h0002, 16'h2222);
    @(negedge clk);
    chk("b_pending_ready", wr_ready, 0);
    chk("b_pending_busy", busy, 1);
    send(16'h0003, 16'h3333);
    drain(100);
    @(negedge clk);
    chk("abc_done_count", done_cnt - base, 3);
    chk("abc_busy_after", busy, 0);

    // Request lands exactly in the DONE cycle
    send(16'h00D0, 16'hD0D0);
    for (int n = 0; n < 30 && !done; n++) @(negedge clk);
    chk("d_reached_done", done, 1);
    send(16'h00E0, 16'hE0E0);
    @(negedge clk);
    chk("e_no_idle_busy", busy, 1);
    chk("e_no_idle_ce", ce, 0);
    drain(40);

    // Reset in the middle of PULSE with a write pending
    @(negedge clk);
    send(16'h0AAA, 16'hAAAA);
    for (int n = 0; n < 20 && we; n++) @(negedge clk);
    send(16'h0BBB, 16'hBBBB);
    @(negedge clk);
    chk("pre_rst_pulse", we, 0);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_strobes", {ce, we, dq_oe, done}, 4'b1100);
    chk("rst_mid_busy_ready", {busy, wr_ready}, 2'b01);
    chk("rst_mid_addr", flash_addr, 16'h0000);
    sb_q.delete();
    last_due = 0;
    base = done_cnt;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 25; n++) @(negedge clk);
    chk("rst_no_done", done_cnt - base, 0);
    chk("rst_busy_after", busy, 0);

    // Minimum timing instance
    @(negedge clk);
    wr_req_f = 1'b1; wr_addr_f = 16'h5A5A; wr_data_f = 16'hC3C3;
    chk("fast_ready", wr_ready_f, 1);
    @(posedge clk);
    #1 wr_req_f = 1'b0;
    done_at = -1; we_lo = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (!we_f) we_lo++;
      if (done_f && done_at < 0) begin
        done_at = k;
        chk("fast_addr", flash_addr_f, 16'h5A5A);
        chk("fast_data", flash_dq_f, 16'hC3C3);
      end
    end
    $display("txn fast addr=%h data=%h done_edge=%0d we_low=%0d", flash_addr_f, flash_dq_f, done_at, we_lo);
    chk("fast_done_cycle", done_at, 3);
    chk("fast_we_low", we_lo, 1);
    chk("fast_busy_after", busy_f, 0);

    chk("sb_empty_end", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
